// File: rtl/dmem_wait.sv
// rtl/dmem_wait.sv - byte/half/word data memory with configurable access latency and fault reporting
module dmem_wait #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        ready,
   output logic [1:0]  err
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;

   // Reject configurations this generation cannot build.
   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("dmem_wait: DATA_WIDTH must be 32");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW > 29) begin : g_bad_depth
         $error("dmem_wait: DEPTH must be a power of two between 2 and 2^29");
      end
      if ((BASE_ADDR & 32'(DEPTH * 4 - 1)) != 32'h0) begin : g_bad_base
         $error("dmem_wait: BASE_ADDR must be aligned to DEPTH*4 bytes");
      end
      if (LATENCY > 7) begin : g_bad_latency
         $error("dmem_wait: LATENCY must be in 0..7");
      end
   endgenerate

   logic [31:0]   mem_q [DEPTH];

   // Operands of the access being serviced: live inputs when idle, latched copy otherwise.
   logic          sel_we;
   logic [1:0]    sel_size;
   logic          sel_uns;
   logic [31:0]   sel_a;
   logic [31:0]   sel_wd;

   logic [AW+1:0] offset;
   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic [1:0]    fault;
   logic [31:0]   word_rd;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic [31:0]   resp_rd;
   logic [31:0]   store_word;
   logic [3:0]    be;
   logic          wr_en;

   // Address decode and fault classification; misalignment takes priority over range.
   always_comb begin
      offset = sel_a[AW+1:0] - BASE_ADDR[AW+1:0];
      widx   = offset[AW+1:2];
      lane   = offset[1:0];
      fault  = ERR_OK;
      if ((sel_size == 2'b01 && lane[0]) || (sel_size[1] && lane != 2'b00)) begin
         fault = ERR_ALIGN;
      end else if (sel_a[31:AW+2] != BASE_ADDR[31:AW+2]) begin
         fault = ERR_RANGE;
      end
   end

   // Lane selection and sign/zero extension of load data; stores and faults return zero.
   always_comb begin
      word_rd  = mem_q[widx];
      byte_sel = word_rd[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];
      case (sel_size)
         2'b00:   load_val = {{24{byte_sel[7] & ~sel_uns}}, byte_sel};
         2'b01:   load_val = {{16{half_sel[15] & ~sel_uns}}, half_sel};
         default: load_val = word_rd;
      endcase
      resp_rd = (!sel_we && fault == ERR_OK) ? load_val : 32'h0;
   end

   // Byte enables and replicated store data so any enabled lane sees its bytes.
   always_comb begin
      case (sel_size)
         2'b00: begin
            be         = 4'b0001 << lane;
            store_word = {4{sel_wd[7:0]}};
         end
         2'b01: begin
            be         = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{sel_wd[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            store_word = sel_wd;
         end
      endcase
   end

   // Storage array: only enabled bytes change on a committed store.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[widx][8*i +: 8] <= store_word[8*i +: 8];
            end
         end
      end
   end

   generate
      if (LATENCY == 0) begin : g_comb
         assign sel_we   = we;
         assign sel_size = size;
         assign sel_uns  = unsigned_ld;
         assign sel_a    = a;
         assign sel_wd   = wd;
         assign wr_en    = req && we && (fault == ERR_OK) && !rst;
         assign ready    = req;
         assign rd       = req ? resp_rd : 32'h0;
         assign err      = req ? fault : ERR_OK;
      end else begin : g_fsm
         typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

         localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

         state_e      state_q;
         logic [2:0]  cnt_q;
         logic        lat_we_q;
         logic [1:0]  lat_size_q;
         logic        lat_uns_q;
         logic [31:0] lat_a_q;
         logic [31:0] lat_wd_q;
         logic        ready_q;
         logic [31:0] rd_q;
         logic [1:0]  err_q;
         logic        live;

         assign live     = (state_q == S_IDLE);
         assign sel_we   = live ? we          : lat_we_q;
         assign sel_size = live ? size        : lat_size_q;
         assign sel_uns  = live ? unsigned_ld : lat_uns_q;
         assign sel_a    = live ? a           : lat_a_q;
         assign sel_wd   = live ? wd          : lat_wd_q;

         // A store commits at the edge closing DONE unless reset aborts it.
         assign wr_en = (state_q == S_DONE) && lat_we_q && (err_q == ERR_OK) && !rst;

         // Reset during DONE suppresses the response of the aborted access.
         assign ready = ready_q & ~rst;
         assign rd    = rst ? 32'h0 : rd_q;
         assign err   = rst ? ERR_OK : err_q;

         // Request sequencer: accept in IDLE, count down in WAIT, respond for one cycle in DONE.
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= S_IDLE;
               cnt_q   <= 3'd0;
               ready_q <= 1'b0;
               rd_q    <= 32'h0;
               err_q   <= ERR_OK;
            end else begin
               ready_q <= 1'b0;
               rd_q    <= 32'h0;
               err_q   <= ERR_OK;
               case (state_q)
                  S_IDLE: begin
                     if (req) begin
                        lat_we_q   <= we;
                        lat_size_q <= size;
                        lat_uns_q  <= unsigned_ld;
                        lat_a_q    <= a;
                        lat_wd_q   <= wd;
                        if (LATENCY == 1) begin
                           state_q <= S_DONE;
                           ready_q <= 1'b1;
                           rd_q    <= resp_rd;
                           err_q   <= fault;
                        end else begin
                           state_q <= S_WAIT;
                           cnt_q   <= CNT_INIT;
                        end
                     end
                  end
                  S_WAIT: begin
                     if (cnt_q == 3'd0) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        rd_q    <= resp_rd;
                        err_q   <= fault;
                     end else begin
                        cnt_q <= cnt_q - 3'd1;
                     end
                  end
                  S_DONE: begin
                     state_q <= S_IDLE;
                  end
                  default: begin
                     state_q <= S_IDLE;
                  end
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_dmem_wait.sv
// tb/tb_dmem_wait.sv - self-checking bench for dmem_wait at latencies 0, 1 and 2
module tb_dmem_wait;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_v;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd0, rd1, rd2;
   logic        ready0, ready1, ready2;
   logic [1:0]  err0, err1, err2;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rd;
      logic [1:0]  err;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   typedef struct packed {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] ad;
      logic [31:0] wdat;
      logic [31:0] erd;
      logic [1:0]  eerr;
   } vec_t;

   vec_t vt[$];

   logic [31:0] hs_a   [9] = '{32'h20, 32'h24, 32'h28, 32'h24, 32'h20, 32'h20, 32'h28, 32'h20, 32'h24};
   logic [31:0] hs_exp [3] = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_wait #(.DEPTH(256), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .size(size), .unsigned_ld(uns),
      .a(a), .wd(wd), .rd(rd2), .ready(ready2), .err(err2));

   dmem_wait #(.DEPTH(256), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .size(size), .unsigned_ld(uns),
      .a(a), .wd(wd), .rd(rd1), .ready(ready1), .err(err1));

   dmem_wait #(.DEPTH(256), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
      .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .size(size), .unsigned_ld(uns),
      .a(a), .wd(wd), .rd(rd0), .ready(ready0), .err(err0));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] ad, input logic [31:0] wdat,
                               input logic [31:0] erd, input logic [1:0] eerr);
      vec_t v;
      v.w = w; v.sz = sz; v.u = u; v.ad = ad; v.wdat = wdat; v.erd = erd; v.eerr = eerr;
      return v;
   endfunction

   task automatic push(input int d, input logic [31:0] erd, input logic [1:0] eerr, input int due);
      exp_t e;
      e.rd = erd; e.err = eerr; e.due = due;
      if (d == 0) q0.push_back(e);
      else if (d == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic on_ready(input int d, input logic [31:0] rv, input logic [1:0] ev);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      else if (d == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL spurious_ready_L%0d: ready=1 at cycle %0d, expected 0", d, cyc);
      end else begin
         chk($sformatf("L%0d_rd_due%0d", d, e.due), rv, e.rd);
         chk($sformatf("L%0d_err_due%0d", d, e.due), {30'b0, ev}, {30'b0, e.err});
         chk($sformatf("L%0d_ready_cycle_due%0d", d, e.due), cyc, e.due);
      end
   endtask

   // Issue one access to the latency-d instance, holding req until its ready cycle has passed.
   task automatic acc(input int d, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] ad, input logic [31:0] wdat,
                      input logic [31:0] erd, input logic [1:0] eerr);
      we = w; size = sz; uns = u; a = ad; wd = wdat;
      req_v[d] = 1'b1;
      push(d, erd, eerr, cyc + d);
      repeat (d + 1) @(posedge clk);
      #1 req_v[d] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (ready0 === 1'b1) on_ready(0, rd0, err0);
      if (ready1 === 1'b1) on_ready(1, rd1, err1);
      if (ready2 === 1'b1) on_ready(2, rd2, err2);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_v = 3'b000; we = 1'b0; size = 2'd2; uns = 1'b0; a = 32'h0; wd = 32'h0;

      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h000, 32'hCAFEF00D, 32'h0,        2'd0));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        2'd0));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 2'd0));
      vt.push_back(mk(1'b1, 2'd0, 1'b0, 32'h011, 32'h00000080, 32'h0,        2'd0));
      vt.push_back(mk(1'b0, 2'd0, 1'b0, 32'h011, 32'h0,        32'hFFFFFF80, 2'd0));
      vt.push_back(mk(1'b0, 2'd0, 1'b1, 32'h011, 32'h0,        32'h00000080, 2'd0));
      vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'hFFFFDEAD, 2'd0));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEAD80EF, 2'd0));
      vt.push_back(mk(1'b0, 2'd1, 1'b1, 32'h010, 32'h0,        32'h000080EF, 2'd0));
      vt.push_back(mk(1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'hFFFFFFDE, 2'd0));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h012, 32'h0,        32'h0,        2'd1));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h400, 32'h11111111, 32'h0,        2'd2));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hCAFEF00D, 2'd0));
      vt.push_back(mk(1'b0, 2'd1, 1'b0, 32'h401, 32'h0,        32'h0,        2'd1));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h014, 32'h01234567, 32'h0,        2'd0));
      vt.push_back(mk(1'b1, 2'd1, 1'b0, 32'h016, 32'h0000ABCD, 32'h0,        2'd0));
      vt.push_back(mk(1'b0, 2'd3, 1'b0, 32'h014, 32'h0,        32'hABCD4567, 2'd0));
      vt.push_back(mk(1'b0, 2'd1, 1'b1, 32'h016, 32'h0,        32'h0000ABCD, 2'd0));
      vt.push_back(mk(1'b1, 2'd0, 1'b0, 32'h014, 32'hFFFFFF99, 32'h0,        2'd0));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h014, 32'h0,        32'hABCD4599, 2'd0));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h020, 32'hAAAA0001, 32'h0,        2'd0));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h024, 32'hAAAA0002, 32'h0,        2'd0));
      vt.push_back(mk(1'b1, 2'd2, 1'b0, 32'h028, 32'hAAAA0003, 32'h0,        2'd0));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h7FFFFFFC, 32'h0,   32'h0,        2'd2));
      vt.push_back(mk(1'b1, 2'd1, 1'b0, 32'h013, 32'h0000FFFF, 32'h0,        2'd1));
      vt.push_back(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEAD80EF, 2'd0));

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_ready_L2", {31'b0, ready2}, 32'h0);
      chk("reset_rd_L2", rd2, 32'h0);
      chk("reset_err_L2", {30'b0, err2}, 32'h0);
      chk("reset_ready_L1", {31'b0, ready1}, 32'h0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vt.size(); i++) begin
         acc(2, vt[i].w, vt[i].sz, vt[i].u, vt[i].ad, vt[i].wdat, vt[i].erd, vt[i].eerr);
      end

      // req held high with an address that changes every cycle
      we = 1'b0; size = 2'd2; uns = 1'b0;
      for (int k = 0; k < 9; k++) begin
         a = hs_a[k];
         req_v[2] = 1'b1;
         if (k % 3 == 0) push(2, hs_exp[k / 3], 2'd0, cyc + 2);
         @(posedge clk);
         #1;
      end
      req_v[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset while the store is waiting
      we = 1'b1; size = 2'd2; a = 32'h20; wd = 32'h12345678; req_v[2] = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_ready", {31'b0, ready2}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0; req_v[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hAAAA0001, 2'd0);

      // reset during the DONE cycle of a store
      we = 1'b1; size = 2'd2; a = 32'h24; wd = 32'h87654321; req_v[2] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_done_ready", {31'b0, ready2}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0; req_v[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc(2, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'hAAAA0002, 2'd0);

      // single-cycle-wait build
      acc(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5A5A5A, 32'h0,        2'd0);
      acc(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h5A5A5A5A, 2'd0);
      acc(1, 1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        32'h0,        2'd1);
      acc(1, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0,        32'h0000005A, 2'd0);

      // combinational build: store then load in the very next cycle
      acc(0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h76543210, 32'h0,        2'd0);
      acc(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        32'h76543210, 2'd0);
      acc(0, 1'b0, 2'd0, 1'b0, 32'h83, 32'h0,        32'h00000076, 2'd0);
      acc(0, 1'b0, 2'd2, 1'b0, 32'h81, 32'h0,        32'h0,        2'd1);
      we = 1'b0; size = 2'd2; a = 32'h83;
      @(negedge clk);
      chk("l0_idle_ready", {31'b0, ready0}, 32'h0);
      chk("l0_idle_rd", rd0, 32'h0);
      chk("l0_idle_err", {30'b0, err0}, 32'h0);

      repeat (4) @(posedge clk);
      #1;
      chk("pending_L0", q0.size(), 32'h0);
      chk("pending_L1", q1.size(), 32'h0);
      chk("pending_L2", q2.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
